// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// alu_rr_scheduler - round-robin front end sharing one pipelined ALU between
// NUM_REQ requesters. Define ALU_SCHED_PRIO_EN for strict requester-0 priority.
// Rev 1.0
// ============================================================================
module alu_rr_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int OP_W      = 3,
  parameter int ALU_LAT   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b_i,
  input  logic [NUM_REQ*OP_W-1:0]    req_op_i,
  output logic [WIDTH-1:0]           alu_a_o,
  output logic [WIDTH-1:0]           alu_b_o,
  output logic [OP_W-1:0]            alu_op_o,
  input  logic [WIDTH-1:0]           alu_out_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [WIDTH-1:0]           rsp_data_o,
  output logic                       busy_o
);

  localparam int c_ID_W  = $clog2(NUM_REQ);
  localparam int c_CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int c_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [c_ID_W:0] c_NUM_REQ = (c_ID_W + 1)'(NUM_REQ);

  logic [WIDTH-1:0]   w_a  [NUM_REQ];
  logic [WIDTH-1:0]   w_b  [NUM_REQ];
  logic [OP_W-1:0]    w_op [NUM_REQ];

  logic [c_ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [c_CNT_W-1:0] credits_q, credits_d;
  logic [OP_W-1:0]    alu_op_q;
  logic [ALU_LAT-1:0] tag_vld_q;
  logic [c_ID_W-1:0]  tag_id_q [ALU_LAT];
  logic [c_ID_W-1:0]  fifo_id_q [RSP_DEPTH];
  logic [WIDTH-1:0]   fifo_data_q [RSP_DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;

  logic               w_can_issue;
  logic               w_found;
  logic               w_issue;
  logic               w_ptr_upd;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic [c_ID_W-1:0]  w_win;
  logic [c_ID_W:0]    w_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_a[g]  = req_a_i[g*WIDTH +: WIDTH];
    assign w_b[g]  = req_b_i[g*WIDTH +: WIDTH];
    assign w_op[g] = req_op_i[g*OP_W +: OP_W];
  end

  // Gating with rst_n keeps req_ready low for the whole reset assertion.
  assign w_can_issue = rst_n && (credits_q != '0);

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, rr_ptr_q} + (c_ID_W + 1)'(k);
      if (w_idx >= c_NUM_REQ) begin
        w_idx = w_idx - c_NUM_REQ;
      end
      if (!w_found && req_valid_i[w_idx[c_ID_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[c_ID_W-1:0];
      end
    end
`ifdef ALU_SCHED_PRIO_EN
    if (req_valid_i[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
  end

  assign w_issue = w_can_issue && w_found;

  always_comb begin
    req_ready_o = '0;
    if (w_issue) begin
      req_ready_o[w_win] = 1'b1;
    end
  end

  assign alu_a_o  = w_issue ? w_a[w_win] : '0;
  assign alu_b_o  = w_issue ? w_b[w_win] : '0;
  assign alu_op_o = alu_op_q;

`ifdef ALU_SCHED_PRIO_EN
  // Requester 0 only ever wins through priority, so it never moves the pointer.
  assign w_ptr_upd = w_issue && (w_win != '0);
`else
  assign w_ptr_upd = w_issue;
`endif

  assign rr_ptr_d = !w_ptr_upd ? rr_ptr_q :
                    (w_win == c_ID_W'(NUM_REQ - 1)) ? '0 : w_win + c_ID_W'(1);

  assign w_push      = tag_vld_q[ALU_LAT-1];
  assign rsp_valid_o = (count_q != '0);
  assign w_pop       = rsp_valid_o && rsp_ready_i;
  assign w_full      = (count_q == c_CNT_W'(RSP_DEPTH));
  assign rsp_id_o    = fifo_id_q[rd_ptr_q];
  assign rsp_data_o  = fifo_data_q[rd_ptr_q];
  assign busy_o      = (|tag_vld_q) || rsp_valid_o;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(RSP_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign wr_ptr_d = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  assign rd_ptr_d = w_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

  always_comb begin
    credits_d = credits_q;
    count_d   = count_q;
    if (w_issue && !w_pop) begin
      credits_d = credits_q - c_CNT_W'(1);
    end else if (!w_issue && w_pop) begin
      credits_d = credits_q + c_CNT_W'(1);
    end
    if (w_push && !w_pop) begin
      count_d = count_q + c_CNT_W'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      credits_q <= c_CNT_W'(RSP_DEPTH);
      alu_op_q  <= '0;
      tag_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int s = 0; s < ALU_LAT; s++) begin
        tag_id_q[s] <= '0;
      end
      for (int e = 0; e < RSP_DEPTH; e++) begin
        fifo_id_q[e]   <= '0;
        fifo_data_q[e] <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      if (w_issue) begin
        alu_op_q <= w_op[w_win];
      end
      tag_vld_q[0] <= w_issue;
      tag_id_q[0]  <= w_win;
      for (int s = 1; s < ALU_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      if (w_push) begin
        fifo_id_q[wr_ptr_q]   <= tag_id_q[ALU_LAT-1];
        fifo_data_q[wr_ptr_q] <= alu_out_i;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));
`endif

endmodule
`default_nettype wire
